// File: rtl/beat_qualifier.sv
// Turns the threshold detector's level output into clean one-cycle beat events,
// with glitch qualification, refractory hold-off and beat-to-beat interval measurement.
module beat_qualifier #(
  parameter int MIN_HIGH_CYCLES   = 4,
  parameter int REFRACTORY_CYCLES = 2_500_000,
  parameter int INTERVAL_WIDTH    = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      beat_pulse,
  output logic                      beat_strobe,
  output logic [INTERVAL_WIDTH-1:0] beat_interval,
  output logic                      interval_valid,
  output logic [15:0]               beat_count,
  output logic                      in_refractory
);

  localparam int QUAL_W = $clog2(MIN_HIGH_CYCLES + 1);
  localparam int HOLD_W = $clog2(REFRACTORY_CYCLES + 1);
  localparam logic [QUAL_W-1:0] QUAL_LAST = QUAL_W'(MIN_HIGH_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REFRACTORY_CYCLES - 1);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    QUALIFY  = 2'd1,
    HOLDOFF  = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [QUAL_W-1:0]         qual_q, qual_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [INTERVAL_WIDTH-1:0] int_cnt_q;
  logic                      no_prev_q;
  logic                      fire;
  logic                      int_sat;

  assign int_sat = &int_cnt_q;

  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    hold_d  = hold_q;
    fire    = 1'b0;
    case (state_q)
      ARMED: begin
        if (beat_pulse) begin
          qual_d = QUAL_W'(1);
          if (MIN_HIGH_CYCLES == 1) fire = 1'b1;
          else state_d = QUALIFY;
        end
      end
      QUALIFY: begin
        if (beat_pulse) begin
          qual_d = qual_q + QUAL_W'(1);
          if (qual_d == QUAL_LAST) fire = 1'b1;
        end else begin
          state_d = ARMED;
          qual_d  = '0;
        end
      end
      HOLDOFF: begin
        if (hold_q == HOLD_LAST) state_d = WAIT_LOW;
        else hold_d = hold_q + HOLD_W'(1);
      end
      WAIT_LOW: begin
        if (!beat_pulse) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
    // The hold-off window counts from the strobe cycle itself.
    if (fire) begin
      state_d = HOLDOFF;
      hold_d  = '0;
      qual_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARMED;
      qual_q         <= '0;
      hold_q         <= '0;
      int_cnt_q      <= '1;
      no_prev_q      <= 1'b1;
      beat_strobe    <= 1'b0;
      interval_valid <= 1'b0;
      beat_interval  <= '0;
      beat_count     <= '0;
      in_refractory  <= 1'b0;
    end else if (clear) begin
      state_q        <= ARMED;
      qual_q         <= '0;
      hold_q         <= '0;
      int_cnt_q      <= '1;
      no_prev_q      <= 1'b1;
      beat_strobe    <= 1'b0;
      interval_valid <= 1'b0;
      beat_interval  <= '0;
      beat_count     <= '0;
      in_refractory  <= 1'b0;
    end else begin
      state_q       <= state_d;
      qual_q        <= qual_d;
      hold_q        <= hold_d;
      beat_strobe   <= fire;
      in_refractory <= (state_d == HOLDOFF) || (state_d == WAIT_LOW);
      if (fire) begin
        beat_count <= beat_count + 16'd1;
        int_cnt_q  <= INTERVAL_WIDTH'(1);
        no_prev_q  <= 1'b0;
        // A saturated counter means the true interval is unknown, so keep the old one.
        if (!no_prev_q && !int_sat) begin
          beat_interval  <= int_cnt_q;
          interval_valid <= 1'b1;
        end else begin
          interval_valid <= 1'b0;
        end
      end else begin
        interval_valid <= 1'b0;
        if (!int_sat) int_cnt_q <= int_cnt_q + INTERVAL_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_beat_qualifier.sv
// Bench for beat_qualifier: two instances (long and short interval counters),
// an edge-number reference model compared every cycle, plus directed literal checks.
module tb_beat_qualifier;

  localparam int  MIN_H   = 4;
  localparam int  REF_A   = 100;
  localparam int  REF_B   = 20;
  localparam int  W_A     = 26;
  localparam int  W_B     = 8;
  localparam longint SAT_A = (longint'(1) << W_A) - 1;
  localparam longint SAT_B = (longint'(1) << W_B) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear, pulse_a, pulse_b;
  logic           strobe_a, valid_a, ref_a;
  logic [W_A-1:0] int_a;
  logic [15:0]    cnt_a;
  logic           strobe_b, valid_b, ref_b;
  logic [W_B-1:0] int_b;
  logic [15:0]    cnt_b;

  beat_qualifier #(.MIN_HIGH_CYCLES(MIN_H), .REFRACTORY_CYCLES(REF_A), .INTERVAL_WIDTH(W_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .beat_pulse(pulse_a),
    .beat_strobe(strobe_a), .beat_interval(int_a), .interval_valid(valid_a),
    .beat_count(cnt_a), .in_refractory(ref_a)
  );

  beat_qualifier #(.MIN_HIGH_CYCLES(MIN_H), .REFRACTORY_CYCLES(REF_B), .INTERVAL_WIDTH(W_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .beat_pulse(pulse_b),
    .beat_strobe(strobe_b), .beat_interval(int_b), .interval_valid(valid_b),
    .beat_count(cnt_b), .in_refractory(ref_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: reasons about edge numbers of the fire events.
  int          edge_n[2]    = '{0, 0};
  int          fire_edge[2] = '{0, 0};
  int          run[2]       = '{0, 0};
  bit          armed[2]     = '{1'b1, 1'b1};
  bit          has_prev[2]  = '{1'b0, 1'b0};
  bit          e_strobe[2]  = '{1'b0, 1'b0};
  bit          e_valid[2]   = '{1'b0, 1'b0};
  bit          e_ref[2]     = '{1'b0, 1'b0};
  longint      e_int[2]     = '{0, 0};
  logic [15:0] e_cnt[2]     = '{16'd0, 16'd0};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      armed[i] = 1'b1; has_prev[i] = 1'b0; run[i] = 0; fire_edge[i] = 0;
      e_strobe[i] = 1'b0; e_valid[i] = 1'b0; e_ref[i] = 1'b0;
      e_int[i] = 0; e_cnt[i] = 16'd0;
    end
  endtask

  task automatic model_step(input int i, input bit p, input int refr, input longint sat);
    edge_n[i]++;
    e_strobe[i] = 1'b0;
    e_valid[i]  = 1'b0;
    if (!armed[i]) begin
      if (edge_n[i] > fire_edge[i] + refr && !p) begin
        armed[i] = 1'b1;
        e_ref[i] = 1'b0;
      end
    end else if (!p) begin
      run[i] = 0;
    end else begin
      run[i]++;
      if (run[i] == MIN_H) begin
        e_strobe[i] = 1'b1;
        e_cnt[i]++;
        if (has_prev[i] && longint'(edge_n[i] - fire_edge[i]) < sat) begin
          e_int[i]   = edge_n[i] - fire_edge[i];
          e_valid[i] = 1'b1;
        end
        has_prev[i]  = 1'b1;
        fire_edge[i] = edge_n[i];
        armed[i]     = 1'b0;
        run[i]       = 0;
        e_ref[i]     = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) model_reset();
    else begin
      model_step(0, pulse_a, REF_A, SAT_A);
      model_step(1, pulse_b, REF_B, SAT_B);
    end
  end

  always @(negedge clk) begin
    chk("a_strobe",   strobe_a, e_strobe[0]);
    chk("a_valid",    valid_a,  e_valid[0]);
    chk("a_interval", int_a,    e_int[0]);
    chk("a_count",    cnt_a,    e_cnt[0]);
    chk("a_refract",  ref_a,    e_ref[0]);
    chk("b_strobe",   strobe_b, e_strobe[1]);
    chk("b_valid",    valid_b,  e_valid[1]);
    chk("b_interval", int_b,    e_int[1]);
    chk("b_count",    cnt_b,    e_cnt[1]);
    chk("b_refract",  ref_b,    e_ref[1]);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the selected pulse for hi samples, run total cycles, report strobe activity.
  task automatic run_pulse(input bit sel, input int hi, input int total,
                           output int first_k, output int nstr,
                           output bit lvalid, output longint lint);
    first_k = -1; nstr = 0; lvalid = 1'b0; lint = 0;
    if (sel) pulse_b = 1'b1; else pulse_a = 1'b1;
    for (int k = 0; k < total; k++) begin
      @(posedge clk); #1;
      if (sel ? strobe_b : strobe_a) begin
        if (first_k < 0) first_k = k;
        nstr++;
        lvalid = sel ? valid_b : valid_a;
        lint   = sel ? longint'(int_b) : longint'(int_a);
      end
      if (k == hi - 1) begin
        if (sel) pulse_b = 1'b0; else pulse_a = 1'b0;
      end
    end
  endtask

  int     fk, ns;
  bit     lv;
  longint li;

  initial begin
    rst_n = 1'b0; clear = 1'b0; pulse_a = 1'b0; pulse_b = 1'b0;
    tick(3);
    chk("rst_count",    cnt_a, 0);
    chk("rst_strobe",   strobe_a, 0);
    chk("rst_valid",    valid_a, 0);
    chk("rst_interval", int_a, 0);
    chk("rst_refract",  ref_a, 0);
    rst_n = 1'b1;
    tick(2);

    run_pulse(1'b0, 3, 13, fk, ns, lv, li);
    chk("glitch_strobes", ns, 0);
    chk("glitch_count",   cnt_a, 0);
    chk("glitch_refract", ref_a, 0);

    run_pulse(1'b0, 10, 500, fk, ns, lv, li);
    chk("basic_latency", fk, 3);
    chk("basic_strobes", ns, 1);
    chk("basic_valid",   lv, 0);
    chk("basic_count",   cnt_a, 1);

    run_pulse(1'b0, 10, 300, fk, ns, lv, li);
    chk("intv_latency",  fk, 3);
    chk("intv_valid",    lv, 1);
    chk("intv_interval", li, 500);
    chk("intv_count",    cnt_a, 2);

    run_pulse(1'b0, 300, 302, fk, ns, lv, li);
    chk("hold_strobes",  ns, 1);
    chk("hold_interval", li, 300);
    chk("hold_refract",  ref_a, 0);
    run_pulse(1'b0, 10, 150, fk, ns, lv, li);
    chk("rearm_latency",  fk, 3);
    chk("rearm_interval", li, 302);

    run_pulse(1'b1, 10, 120, fk, ns, lv, li);
    chk("sat_first_valid", lv, 0);
    run_pulse(1'b1, 10, 300, fk, ns, lv, li);
    chk("sat_base_valid",    lv, 1);
    chk("sat_base_interval", li, 120);
    run_pulse(1'b1, 10, 100, fk, ns, lv, li);
    chk("sat_valid",    lv, 0);
    chk("sat_interval", li, 120);
    run_pulse(1'b1, 10, 50, fk, ns, lv, li);
    chk("post_sat_valid",    lv, 1);
    chk("post_sat_interval", li, 100);
    chk("post_sat_count",    cnt_b, 4);

    pulse_a = 1'b1;
    tick(6);
    chk("pre_rst_refract", ref_a, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_count",    cnt_a, 0);
    chk("arst_refract",  ref_a, 0);
    chk("arst_interval", int_a, 0);
    chk("arst_strobe",   strobe_a, 0);
    pulse_a = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    pulse_a = 1'b1;
    tick(3);
    clear = 1'b1;
    tick(1);
    chk("clr_strobe", strobe_a, 0);
    chk("clr_count",  cnt_a, 0);
    clear = 1'b0;
    pulse_a = 1'b0;
    tick(3);

    run_pulse(1'b0, 10, 50, fk, ns, lv, li);
    chk("after_clr_latency", fk, 3);
    chk("after_clr_valid",   lv, 0);
    chk("after_clr_count",   cnt_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_qualifier.md
# beat_qualifier

Sequential stage directly downstream of the combinational SNR threshold detector: consumes its level-type `beat_pulse` (high whenever `snr_db >= THRESHOLD`) and produces clean, one-cycle beat events. It suppresses glitches with a minimum-high qualification window, blocks retriggering with a refractory hold-off, and measures the clock-cycle interval between consecutive beats for the tempo/visualiser stages further down.

## Interface
- `MIN_HIGH_CYCLES`, 4: consecutive high samples of `beat_pulse` required to accept a beat (>= 1).
- `REFRACTORY_CYCLES`, 2_500_000: cycles after a beat during which input is ignored (>= 1; 50 ms at 50 MHz).
- `INTERVAL_WIDTH`, 26: width of the interval counter (2^INTERVAL_WIDTH > REFRACTORY_CYCLES).

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear; same effect as reset, takes priority over all other inputs.
- `beat_pulse`  in  1  threshold-detector output, synchronous to `clk`.
- `beat_strobe`  out  1  one-cycle pulse per accepted beat.
- `beat_interval`  out  INTERVAL_WIDTH  cycles between the last two strobes; held until next valid update.
- `interval_valid`  out  1  one-cycle pulse, coincident with `beat_strobe`, when `beat_interval` was updated.
- `beat_count`  out  16  accepted beats since reset/clear, wraps 0xFFFF -> 0.
- `in_refractory`  out  1  high while in HOLDOFF or WAIT_LOW.

## Operation
- FSM states: ARMED, QUALIFY, HOLDOFF, WAIT_LOW. Reset/clear state: ARMED.
- ARMED: `beat_pulse`=1 -> QUALIFY with qual count = 1; if MIN_HIGH_CYCLES = 1 go straight to HOLDOFF and fire.
- QUALIFY: each high sample increments qual count; on reaching MIN_HIGH_CYCLES -> HOLDOFF and fire. Any low sample -> ARMED, no strobe, count discarded.
- Fire: registered `beat_strobe`=1 for the first HOLDOFF cycle; `beat_count` += 1 (wrapping).
- HOLDOFF: `beat_pulse` ignored; hold-off counter runs REFRACTORY_CYCLES cycles, then -> WAIT_LOW.
- WAIT_LOW: stay until `beat_pulse` sampled 0, then -> ARMED. A level held high across the whole refractory window never produces a second strobe.
- Interval counter: set to 1 on each strobe cycle; otherwise increments by 1 per cycle, saturating at all-ones.
- On a strobe, if a previous strobe exists since reset/clear and the counter is not saturated: `beat_interval` <= counter value and `interval_valid`=1.
- First strobe after reset/clear, or a strobe with a saturated counter: `interval_valid`=0 and `beat_interval` unchanged.
- Interval semantics: strobes at cycles t1 and t2 give `beat_interval` = t2 - t1. The minimum possible is MIN_HIGH_CYCLES + REFRACTORY_CYCLES + 1.

## Timing
- Reset/clear values: `beat_strobe`=0, `interval_valid`=0, `beat_interval`=0, `beat_count`=0, `in_refractory`=0; interval counter saturated; no-previous-beat flag set.
- Latency: if `beat_pulse` is first sampled high at edge e, `beat_strobe` is high in the cycle following edge e + MIN_HIGH_CYCLES - 1. All outputs are registered.
- `in_refractory` rises in the same cycle as `beat_strobe`, and falls in the cycle after `beat_pulse` is sampled low in WAIT_LOW.
- `rst_n` asserted mid-qualify or mid-holdoff: immediate return to reset values. The next beat after release is treated as a first beat.
- `clear` and a qualifying sample in the same cycle: `clear` wins, no strobe.

## Test plan
- Glitch rejection (MIN_HIGH=4): `beat_pulse` high 3 cycles, then low -> no strobe, `beat_count` stays 0, state ARMED.
- Basic beat: `beat_pulse` high 10 cycles -> exactly one `beat_strobe`, 4 cycles after the first high sample; `beat_count`=1; `interval_valid`=0.
- Interval (REFRACTORY=100): two 10-cycle pulses whose rising edges are 500 cycles apart -> second strobe with `interval_valid`=1 and `beat_interval`=500.
- Refractory / WAIT_LOW: pulse held high 300 cycles (REFRACTORY=100) -> single strobe. A new pulse 2 cycles after the fall -> strobe 4 cycles later.
- Saturation (INTERVAL_WIDTH=8, REFRACTORY=20): beats 300 cycles apart -> second strobe with `interval_valid`=0 and `beat_interval` unchanged. The next beat 100 cycles later -> `beat_interval`=100, valid.
- Async reset mid-HOLDOFF, then `clear` during QUALIFY -> all outputs zero immediately. The following beat gives `beat_count`=1 with no `interval_valid`.
